// File: rtl/fifo_rd_unpacker.sv
// Read-side unpacker for a RAM FIFO: pulls 32-bit words with a one-cycle read
// latency and emits them as 32/16/8-bit beats over a valid/ready handshake.
module fifo_rd_unpacker #(
    parameter int unsigned BIG_ENDIAN        = 0,
    parameter int unsigned FLUSH_ON_RST_ONLY = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EMPTY,
    output logic        REN,
    input  logic [31:0] RDATA,
    input  logic [1:0]  OMODE,
    input  logic        FLUSH,
    output logic [31:0] ODATA,
    output logic        OVALID,
    input  logic        OREADY,
    output logic        BUSY
);

    localparam logic [1:0] MODE_W32  = 2'b00;
    localparam logic [1:0] MODE_W16  = 2'b01;
    localparam logic       BIG_LANES = (BIG_ENDIAN != 0);
    localparam logic       FLUSH_EN  = (FLUSH_ON_RST_ONLY == 0);

    // Index of the final beat of a word for a given beat width.
    function automatic logic [1:0] last_lane(input logic [1:0] mode);
        logic [1:0] last;
        case (mode)
            MODE_W32: last = 2'd0;
            MODE_W16: last = 2'd1;
            default:  last = 2'd3;
        endcase
        return last;
    endfunction

    function automatic logic [31:0] select_beat(input logic [31:0] word,
                                                input logic [1:0]  mode,
                                                input logic [1:0]  lane);
        logic [1:0]  idx;
        logic [31:0] beat;
        idx  = BIG_LANES ? (2'd3 - lane) : lane;
        beat = 32'd0;
        case (mode)
            MODE_W32: beat = word;
            MODE_W16: begin
                if (lane[0] ^ BIG_LANES) begin
                    beat = {16'd0, word[31:16]};
                end else begin
                    beat = {16'd0, word[15:0]};
                end
            end
            default: begin
                case (idx)
                    2'd0:    beat = {24'd0, word[7:0]};
                    2'd1:    beat = {24'd0, word[15:8]};
                    2'd2:    beat = {24'd0, word[23:16]};
                    default: beat = {24'd0, word[31:24]};
                endcase
            end
        endcase
        return beat;
    endfunction

    logic [31:0] out_word_q, out_word_d;
    logic [1:0]  out_mode_q, out_mode_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] skid0_q, skid0_d;
    logic [31:0] skid1_q, skid1_d;
    logic        skid_wr_q, skid_wr_d;
    logic        skid_rd_q, skid_rd_d;
    logic [1:0]  skid_cnt_q, skid_cnt_d;
    logic        inflight_q, inflight_d;
    logic [31:0] odata_q, odata_d;
    logic        busy_q, busy_d;

    logic        flush_eff_s;
    logic [2:0]  held_s;
    logic [2:0]  occupancy_s;
    logic        ren_s;
    logic        accept_s;
    logic        last_beat_s;
    logic        out_free_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] skid_head_s;

    // Occupancy, read request and handshake decode from registered state.
    always_comb begin
        flush_eff_s = FLUSH & FLUSH_EN;
        held_s      = {2'b00, out_valid_q} + {1'b0, skid_cnt_q};
        occupancy_s = held_s + {2'b00, inflight_q};
        ren_s       = !RST & !EMPTY & !flush_eff_s & (occupancy_s < 3'd3);
        accept_s    = out_valid_q & OREADY;
        last_beat_s = (lane_q == last_lane(out_mode_q));
        out_free_s  = !out_valid_q | (accept_s & last_beat_s);
        skid_head_s = skid_rd_q ? skid1_q : skid0_q;
    end

    // Next-state: output word load, lane stepping, skid FIFO push/pop, flush.
    always_comb begin
        out_word_d  = out_word_q;
        out_mode_d  = out_mode_q;
        out_valid_d = out_valid_q;
        lane_d      = lane_q;
        skid0_d     = skid0_q;
        skid1_d     = skid1_q;
        skid_wr_d   = skid_wr_q;
        skid_rd_d   = skid_rd_q;
        skid_cnt_d  = skid_cnt_q;
        inflight_d  = ren_s;
        push_s      = 1'b0;
        pop_s       = 1'b0;

        if (flush_eff_s) begin
            // Data landing this edge belongs to a read issued before the flush.
            out_word_d  = 32'd0;
            out_mode_d  = MODE_W32;
            out_valid_d = 1'b0;
            lane_d      = 2'd0;
            skid_wr_d   = 1'b0;
            skid_rd_d   = 1'b0;
            skid_cnt_d  = 2'd0;
            inflight_d  = 1'b0;
        end else begin
            if (out_free_s) begin
                lane_d = 2'd0;
                if (skid_cnt_q != 2'd0) begin
                    out_word_d  = skid_head_s;
                    out_mode_d  = OMODE;
                    out_valid_d = 1'b1;
                    pop_s       = 1'b1;
                    push_s      = inflight_q;
                end else if (inflight_q) begin
                    out_word_d  = RDATA;
                    out_mode_d  = OMODE;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else begin
                push_s = inflight_q;
                if (accept_s) begin
                    lane_d = lane_q + 2'd1;
                end else begin
                    lane_d = lane_q;
                end
            end

            if (push_s) begin
                if (skid_wr_q) begin
                    skid1_d = RDATA;
                end else begin
                    skid0_d = RDATA;
                end
                skid_wr_d = !skid_wr_q;
            end else begin
                skid_wr_d = skid_wr_q;
            end

            if (pop_s) begin
                skid_rd_d = !skid_rd_q;
            end else begin
                skid_rd_d = skid_rd_q;
            end

            skid_cnt_d = skid_cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        end

        odata_d = select_beat(out_word_d, out_mode_d, lane_d);
        busy_d  = out_valid_d | (skid_cnt_d != 2'd0) | inflight_d;
    end

    // State registers; reset clears everything without needing a clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_word_q  <= 32'd0;
            out_mode_q  <= MODE_W32;
            out_valid_q <= 1'b0;
            lane_q      <= 2'd0;
            skid0_q     <= 32'd0;
            skid1_q     <= 32'd0;
            skid_wr_q   <= 1'b0;
            skid_rd_q   <= 1'b0;
            skid_cnt_q  <= 2'd0;
            inflight_q  <= 1'b0;
            odata_q     <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            out_word_q  <= out_word_d;
            out_mode_q  <= out_mode_d;
            out_valid_q <= out_valid_d;
            lane_q      <= lane_d;
            skid0_q     <= skid0_d;
            skid1_q     <= skid1_d;
            skid_wr_q   <= skid_wr_d;
            skid_rd_q   <= skid_rd_d;
            skid_cnt_q  <= skid_cnt_d;
            inflight_q  <= inflight_d;
            odata_q     <= odata_d;
            busy_q      <= busy_d;
        end
    end

    assign REN    = ren_s;
    assign ODATA  = odata_q;
    assign OVALID = out_valid_q;
    assign BUSY   = busy_q;

endmodule

// File: doc/fifo_rd_unpacker.md
FIFO_RD_UNPACKER -- requirements
Module: fifo_rd_unpacker

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 0; 0 = byte/halfword lane 0 (bits [7:0]/[15:0]) emitted first, 1 = most-significant lane first.
REQ-002 SHALL have parameter FLUSH_ON_RST_ONLY, default 0; 1 = FLUSH input ignored (tie-off build).
REQ-003 SHALL have port CLK  input  1  single clock for all sequential logic.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port EMPTY  input  1  RAM FIFO empty flag; 1 = no word readable this cycle.
REQ-006 SHALL have port REN  output  1  read enable to RAM FIFO; RDATA valid exactly one cycle later.
REQ-007 SHALL have port RDATA  input  32  RAM FIFO read data.
REQ-008 SHALL have port OMODE  input  2  output beat width: 00 = 32-bit, 01 = 16-bit, 10 = 8-bit, 11 = treated as 8-bit.
REQ-009 SHALL have port FLUSH  input  1  synchronous discard of all held and in-flight words.
REQ-010 SHALL have port ODATA  output  32  output beat, zero-extended in 16/8-bit modes.
REQ-011 SHALL have port OVALID  output  1  ODATA valid.
REQ-012 SHALL have port OREADY  input  1  consumer accepts beat when OVALID & OREADY.
REQ-013 SHALL have port BUSY  output  1  1 when any word held or in flight.

Function
REQ-014 SHALL store up to 3 words total: 1 output word register + 2-entry skid FIFO; HELD = stored words, INFLIGHT = REN asserted previous cycle.
REQ-015 SHALL drive REN combinationally = !EMPTY & !FLUSH_EFF & (HELD + INFLIGHT < 3); REN SHALL never depend on OREADY.
REQ-016 SHALL capture RDATA on the clock edge one cycle after REN into the skid FIFO, or directly into the output register when it is empty or being vacated that cycle.
REQ-017 SHALL load the output register from skid FIFO head (oldest first) when output empty or last beat of current word is accepted; word order SHALL equal RAM FIFO order.
REQ-018 SHALL latch OMODE into the output register when a word is loaded; OMODE changes mid-word SHALL NOT affect the current word.
REQ-019 SHALL track lane index LANE (0..3); beats per word: 1 (32-bit), 2 (16-bit), 4 (8-bit); LANE advances on each accepted beat, wraps to 0 on last beat and next word loads same edge.
REQ-020 SHALL select lane per BIG_ENDIAN: little-endian 8-bit order [7:0],[15:8],[23:16],[31:24]; big-endian reversed; 16-bit analogous with halfwords.
REQ-021 SHALL hold ODATA and OVALID stable while OVALID & !OREADY.
REQ-022 SHALL sustain one beat per cycle in all modes with EMPTY=0, OREADY=1 continuously; first-word latency: REN at cycle N -> OVALID at cycle N+2.
REQ-023 SHALL deassert OVALID the cycle after the final held beat is accepted if no further word is held or arriving.
REQ-024 FLUSH_EFF = FLUSH & !FLUSH_ON_RST_ONLY; on FLUSH_EFF cycle: REN=0; a beat handshaking that same cycle counts as transferred; next edge clears output register, skid FIFO, LANE, OVALID; RDATA of a read issued the prior cycle SHALL be discarded.
REQ-025 SHALL assert BUSY = (HELD != 0) | INFLIGHT, registered-state based, no dependency on OREADY.
REQ-026 SHALL never overflow storage: HELD + INFLIGHT <= 3 at every edge.

Reset
REQ-027 On RST=1, immediately and without CLK: OVALID=0, ODATA=0, BUSY=0, LANE=0, HELD=0, INFLIGHT=0, latched mode=00; REN SHALL read 0 while RST=1.
REQ-028 Reset asserted with a read in flight SHALL discard that read's RDATA after RST releases.
REQ-029 First REN SHALL be possible in the first cycle after RST deasserts if EMPTY=0.

Verification
REQ-030 OMODE=10, BIG_ENDIAN=0, one word 0x44332211, OREADY=1 -> ODATA 0x11,0x22,0x33,0x44 on 4 consecutive cycles, then OVALID=0.
REQ-031 OMODE=01, BIG_ENDIAN=1, words 0xAAAABBBB,0xCCCCDDDD, OREADY=1 -> ODATA 0xAAAA,0xBBBB,0xCCCC,0xDDDD, no gap cycles.
REQ-032 OMODE=00, EMPTY=0 for 20 words, OREADY=0 -> REN pulses exactly 3 times, BUSY=1; OREADY=1 -> all 20 words in order, 1 per cycle after refill.
REQ-033 OMODE=10, FLUSH pulsed after 2nd beat of word 0x04030201 with read in flight -> OVALID=0 next cycle, in-flight word discarded, next word starts at lane 0.
REQ-034 RST asserted mid-word with OVALID=1 -> OVALID, ODATA, BUSY, REN =0 immediately; after release, EMPTY=0 -> REN same cycle, OVALID 2 cycles later.
REQ-035 OMODE switched 00->10 while 32-bit word 0x11111111 pending -> that word emitted as one 32-bit beat, following word as 4 bytes.
